// File: rtl/phantom_pkg.sv
// phantom_pkg: shared types and helpers for the forwarding scoreboard.
// Entry dest is held at ADDR_MAX bits so one struct serves every ADDR_W up to 16.
package phantom_pkg;
    localparam int ADDR_MAX = 16;
    localparam int SEL_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic [ADDR_MAX-1:0] dest;
        logic                wr;
        logic                load;
    } frwrd_entry_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/frwrd_match.sv
// frwrd_match: youngest-producer priority select and load-use hazard for one source.
// FRWRD_ZERO_REG_EN makes address 0 a constant-zero register that never matches.
module frwrd_match
    import phantom_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH = 2,
    parameter int LOAD_LATENCY = 2,
    parameter int SEL_W = 2
) (
    input  frwrd_entry_t [DEPTH-1:0] entries,
    input  logic [ADDR_W-1:0]        src,
    input  logic                     used,
    output logic [SEL_W-1:0]         sel,
    output logic                     hazard
);
    logic zero;
`ifdef FRWRD_ZERO_REG_EN
    assign zero = src == '0;
`else
    assign zero = 1'b0;
`endif

    // Scan oldest to youngest so the youngest match is the last to overwrite.
    always_comb begin
        sel = SEL_W'(SEL_REGFILE);
        hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--)
            if (entries[k].valid && entries[k].wr && used && !zero &&
                entries[k].dest == ADDR_MAX'(src)) begin
                sel = SEL_W'(k + 1);
                hazard = entries[k].load && (k + 1 < LOAD_LATENCY);
            end
    end
endmodule

// File: rtl/frwrd_scoreboard.sv
// frwrd_scoreboard: shift-register scoreboard of recent producers with operand forwarding selects,
// load-use stall and saturating stall counter. FRWRD_ZERO_REG_EN enables the constant-zero r0.
module frwrd_scoreboard
    import phantom_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int NUM_SRC = 3,
    parameter int DEPTH = 2,
    parameter int LOAD_LATENCY = 2,
    parameter int SEL_W = clog2(DEPTH + 1),
    parameter int CNT_W = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_dest_address,
    input  logic                      issue_register_write_ctrl,
    input  logic                      issue_mem_read_ctrl,
    input  logic [NUM_SRC*ADDR_W-1:0] src_address,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  src_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cycles
);
    frwrd_entry_t [DEPTH-1:0] entries;
    logic [NUM_SRC-1:0] hazard;
    logic push_wr;

`ifdef FRWRD_ZERO_REG_EN
    assign push_wr = issue_register_write_ctrl && issue_dest_address != '0;
`else
    assign push_wr = issue_register_write_ctrl;
`endif

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        frwrd_match #(
            .ADDR_W(ADDR_W),
            .DEPTH(DEPTH),
            .LOAD_LATENCY(LOAD_LATENCY),
            .SEL_W(SEL_W)
        ) u_match (
            .entries(entries),
            .src(src_address[i*ADDR_W +: ADDR_W]),
            .used(src_used[i]),
            .sel(src_sel[i*SEL_W +: SEL_W]),
            .hazard(hazard[i])
        );
    end

    assign stall = issue_valid && |hazard;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entries <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) entries[k].valid <= 1'b0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) entries[k] <= entries[k-1];
            entries[0] <= '{valid: issue_valid && !stall, dest: ADDR_MAX'(issue_dest_address),
                            wr: push_wr, load: issue_mem_read_ctrl};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) stall_cycles <= '0;
        else if (stall && !flush && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_frwrd_scoreboard.sv
// tb_frwrd_scoreboard: directed scoreboard bench for the default build plus a CNT_W=4 saturation instance.
// Zero-register expectations follow FRWRD_ZERO_REG_EN as compiled.
module tb_frwrd_scoreboard;
    typedef struct {
        int         step;
        logic [1:0] sa, sb, sc;
        logic       st;
        logic [15:0] cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic issue_valid, issue_wr, issue_ld, flush;
    logic [3:0] issue_dest;
    logic [11:0] src_address;
    logic [2:0] src_used;
    logic [5:0] src_sel;
    logic stall;
    logic [15:0] stall_cycles;

    logic s_valid;
    logic [5:0] s_sel;
    logic s_stall;
    logic [3:0] s_cnt;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int step_no = 0;

    always #5 clock = ~clock;

    frwrd_scoreboard dut (
        .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid),
        .issue_dest_address(issue_dest), .issue_register_write_ctrl(issue_wr),
        .issue_mem_read_ctrl(issue_ld), .src_address(src_address), .src_used(src_used),
        .flush(flush), .src_sel(src_sel), .stall(stall), .stall_cycles(stall_cycles)
    );

    frwrd_scoreboard #(.CNT_W(4)) u_sat (
        .clock(clock), .reset_n(reset_n), .issue_valid(s_valid),
        .issue_dest_address(4'd1), .issue_register_write_ctrl(1'b1),
        .issue_mem_read_ctrl(1'b1), .src_address(12'h001), .src_used(3'b001),
        .flush(1'b0), .src_sel(s_sel), .stall(s_stall), .stall_cycles(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed %0h expected %0h", name, step_no, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic w, input logic l,
                         input logic [3:0] a, input logic [3:0] b, input logic [2:0] u,
                         input logic f);
        step_no++;
        issue_valid = v; issue_dest = d; issue_wr = w; issue_ld = l;
        src_address = {4'd0, b, a}; src_used = u; flush = f;
    endtask

    task automatic want(input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] sc,
                        input logic st, input logic [15:0] cnt);
        exp_q.push_back('{step: step_no, sa: sa, sb: sb, sc: sc, st: st, cnt: cnt});
    endtask

    task automatic check_out();
        exp_t e;
        #1;
        e = exp_q.pop_front();
        chk("sel_a", 32'(src_sel[1:0]), 32'(e.sa));
        chk("sel_b", 32'(src_sel[3:2]), 32'(e.sb));
        chk("sel_c", 32'(src_sel[5:4]), 32'(e.sc));
        chk("stall", 32'(stall), 32'(e.st));
        chk("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        s_valid = 1'b0;
        drive(1, 4'd3, 1, 1, 4'd3, 4'd3, 3'b111, 0);
        want(0, 0, 0, 0, 0); check_out();
        #1 reset_n = 1'b1;
        // Plain forwarding ages 1 -> 2 -> regfile
        drive(1, 4'd3, 1, 0, 4'd3, 4'd0, 3'b001, 0); want(0, 0, 0, 0, 0); check_out(); tick();
        drive(1, 4'd9, 0, 0, 4'd3, 4'd0, 3'b001, 0); want(1, 0, 0, 0, 0); check_out(); tick();
        drive(1, 4'd9, 0, 0, 4'd3, 4'd0, 3'b001, 0); want(2, 0, 0, 0, 0); check_out(); tick();
        drive(1, 4'd9, 0, 0, 4'd3, 4'd0, 3'b001, 0); want(0, 0, 0, 0, 0); check_out(); tick();
        // Youngest of two r5 writers wins; unused source stays on the regfile
        drive(1, 4'd5, 1, 0, 4'd0, 4'd0, 3'b000, 0); want(0, 0, 0, 0, 0); check_out(); tick();
        drive(1, 4'd5, 1, 0, 4'd0, 4'd0, 3'b000, 0); want(0, 0, 0, 0, 0); check_out(); tick();
        drive(1, 4'd9, 0, 0, 4'd5, 4'd5, 3'b011, 0); want(1, 1, 0, 0, 0); check_out(); tick();
        // Load-use: one stall cycle then forward from stage 2
        drive(1, 4'd2, 1, 1, 4'd0, 4'd0, 3'b000, 0); want(0, 0, 0, 0, 0); check_out(); tick();
        drive(1, 4'd7, 1, 0, 4'd2, 4'd7, 3'b001, 0); want(1, 0, 0, 1, 0); check_out(); tick();
        drive(1, 4'd7, 1, 0, 4'd2, 4'd7, 3'b011, 0); want(2, 0, 0, 0, 1); check_out(); tick();
        drive(1, 4'd9, 0, 0, 4'd0, 4'd7, 3'b010, 0); want(0, 1, 0, 0, 1); check_out(); tick();
        // Flush during a pending hazard: not counted, scoreboard empties
        drive(1, 4'd2, 1, 1, 4'd0, 4'd0, 3'b000, 0); want(0, 0, 0, 0, 1); check_out(); tick();
        drive(1, 4'd7, 1, 0, 4'd2, 4'd0, 3'b001, 1); want(1, 0, 0, 1, 1); check_out(); tick();
        drive(1, 4'd7, 1, 0, 4'd2, 4'd2, 3'b011, 0); want(0, 0, 0, 0, 1); check_out(); tick();
        // Asynchronous reset in the middle of a stall
        drive(1, 4'd2, 1, 1, 4'd0, 4'd0, 3'b000, 0); want(0, 0, 0, 0, 1); check_out(); tick();
        drive(1, 4'd7, 1, 0, 4'd2, 4'd0, 3'b001, 0); want(1, 0, 0, 1, 1); check_out();
        reset_n = 1'b0;
        want(0, 0, 0, 0, 0); check_out();
        reset_n = 1'b1;
        tick();
        // Load writing r0 then a reader of r0
        drive(1, 4'd0, 1, 1, 4'd0, 4'd0, 3'b000, 0); want(0, 0, 0, 0, 0); check_out(); tick();
`ifdef FRWRD_ZERO_REG_EN
        drive(1, 4'd9, 0, 0, 4'd0, 4'd0, 3'b001, 0); want(0, 0, 0, 0, 0); check_out(); tick();
`else
        drive(1, 4'd9, 0, 0, 4'd0, 4'd0, 3'b001, 0); want(1, 0, 0, 1, 0); check_out(); tick();
`endif
        issue_valid = 1'b0;
        // Self-feeding load r1 stalls every other cycle; 4-bit counter must saturate at 15
        step_no++;
        s_valid = 1'b1;
        repeat (11) tick();
        chk("sat_mid", 32'(s_cnt), 32'd5);
        repeat (20) tick();
        chk("sat_full", 32'(s_cnt), 32'd15);
        repeat (19) tick();
        chk("sat_hold", 32'(s_cnt), 32'd15);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frwrd_scoreboard.md
Name: frwrd_scoreboard

Overview:
- Parametrised successor to the fixed two-stage forwarding unit.
- Tracks the destination registers of the last DEPTH instructions that left execute, in a shift-register scoreboard.
- For NUM_SRC operand sources of the instruction in execute, selects the youngest in-flight producer or the register file.
- Detects load-use hazards, asserts stall, inserts bubbles and counts stall cycles.

Parameters:
- ADDR_W, 4: register address width.
- NUM_SRC, 3: operand sources per instruction (a, b, shift amount).
- DEPTH, 2: tracked producer stages after execute (1 = data, 2 = back); legal range 1..7.
- LOAD_LATENCY, 2: first stage index at which a load result is forwardable; legal range 1..DEPTH.
- SEL_W, clog2(DEPTH+1): width of each select field.
- CNT_W, 16: width of the stall counter.

Ports:
- clock, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous active-low reset.
- issue_valid, in, 1: execute holds a real instruction.
- issue_dest_address, in, ADDR_W: destination register of the execute instruction.
- issue_register_write_ctrl, in, 1: execute instruction writes the register file.
- issue_mem_read_ctrl, in, 1: execute instruction is a load.
- src_address, in, NUM_SRC*ADDR_W: source addresses, field i = bits [i*ADDR_W +: ADDR_W].
- src_used, in, NUM_SRC: source i is actually read.
- flush, in, 1: invalidate all tracked entries (branch taken).
- src_sel, out, NUM_SRC*SEL_W: per-source select; 0 = register file, k = stage k.
- stall, out, 1: hold execute and earlier stages.
- stall_cycles, out, CNT_W: saturating count of stalled cycles.

Behaviour:
- Reset (async, reset_n low):
  - all entry valid bits cleared, stall_cycles = 0.
  - src_sel = 0 and stall = 0 while in reset, because the outputs are combinational on cleared entries.
- Entry k (1..DEPTH) holds {valid, dest, wr, load}. Stage 1 is the instruction one cycle past execute.
- Every rising edge, when not flushing:
  - entry k+1 <= entry k.
  - entry 1 <= {issue_valid & ~stall, issue_dest_address, issue_register_write_ctrl, issue_mem_read_ctrl}.
  - On stall a bubble (valid = 0) enters stage 1; older entries still shift.
- Flush: synchronous; all valid bits <= 0 at the edge. Takes priority over shift and push.
- Match for source i, stage k: valid & wr & dest == src_address[i] & src_used[i].
- src_sel[i] (combinational, zero latency): the smallest k that matches; 0 if no stage matches. The youngest producer always wins when several stages hold the same dest.
- Hazard for source i: its selected stage k has load = 1 and k < LOAD_LATENCY.
- stall = issue_valid & OR over all sources of hazard (combinational).
  - Re-evaluated every cycle as the load shifts down; no separate wait state.
  - Consecutive stall cycles = LOAD_LATENCY - k.
- src_sel is still driven during a stall; downstream ignores it while stall = 1.
- stall_cycles: increments at each edge where stall = 1 and flush = 0. Saturates at all-ones with no wrap.
- Simultaneous events:
  - flush with stall: flush wins and no stall is counted; the next cycle's stall is computed from the empty scoreboard (0).
  - issue_valid = 0: stall = 0, bubble pushed.
- DEPTH = 1: there is only stage 1; with LOAD_LATENCY = 1 a load never stalls.

Optional Feature:
- FRWRD_ZERO_REG_EN defined:
  - address 0 is a constant-zero register and is never matched.
  - src_sel = 0 and no hazard for sources addressing 0.
  - an issued write to address 0 enters the scoreboard with wr = 0.
- FRWRD_ZERO_REG_EN undefined: address 0 is treated like any other register.

Decomposition:
- Shared package phantom_pkg holds:
  - sel encoding constant SEL_REGFILE = 0.
  - typedef frwrd_entry_t {valid, dest, wr, load}.
  - a clog2 helper function.
- One natural sub-module: frwrd_match, a per-source priority matcher instantiated NUM_SRC times. It takes the entry array and one source address and returns the select and hazard bit.

Test Plan:
- Defaults. Issue {dest = 3, wr, not load}, next cycle src a = 3 used -> src_sel a = 1, stall = 0. Following cycle, source 3 again with no new writer -> src_sel a = 2. One cycle later -> 0.
- Two writers to r5 in back-to-back cycles, then read r5 -> src_sel = 1, not 2.
- Load to r2, next instruction reads r2 -> stall = 1 for exactly 1 cycle, bubble visible at stage 1, then src_sel = 2, stall_cycles = 1.
- Pending hazard (load r2 in stage 1, reader waiting), assert flush -> stall_cycles unchanged, all src_sel = 0 next cycle. Asserting reset_n low mid-stall clears outputs immediately.
- CNT_W = 4, force 20 stall cycles -> stall_cycles holds 15.
- Compile with FRWRD_ZERO_REG_EN. Write r0, then read r0 -> src_sel = 0, stall = 0, even when the writer is a load.
